// File: rtl/rand_server.sv
// rand_server: round-robin server handing out words from a shared 64-bit LFSR after a seeded warm-up.
// Define RAND_SERVER_ZERO_GUARD_EN to replace an all-zero seed with 64'h1.
module rand_server #(
    parameter int NREQ   = 4,
    parameter int WARMUP = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [63:0]     seed,
    input  logic            seed_load,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [63:0]     rnd_data,
    output logic            busy
);
    localparam int RW = $clog2(NREQ);
    typedef enum logic [1:0] {UNSEEDED, WARM, READY} state_t;
    state_t state, state_nxt;
    logic [63:0] lfsr, lfsr_step, seed_eff;
    logic [7:0] cnt;
    logic [RW-1:0] rr, pick;
    logic found, grant;
`ifdef RAND_SERVER_ZERO_GUARD_EN
    assign seed_eff = (seed == 64'h0) ? 64'h1 : seed;
`else
    assign seed_eff = seed;
`endif
    assign lfsr_step = {lfsr[62:0], lfsr[63] ^ lfsr[61] ^ lfsr[59] ^ lfsr[58]};
    assign busy = (state != READY);
    // First active requester at or after rr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick = '0;
        for (int o = 0; o < NREQ; o++) begin
            if (!found && req[(int'(rr) + o) % NREQ]) begin
                found = 1'b1;
                pick = RW'((int'(rr) + o) % NREQ);
            end
        end
    end
    assign grant = (state == READY) && !seed_load && found;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= UNSEEDED;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (seed_load) state_nxt = WARM;
        else if (state == WARM && cnt == 8'(WARMUP - 1)) state_nxt = READY;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= '0;
            cnt <= '0;
            rr <= '0;
            gnt <= '0;
            rnd_valid <= 1'b0;
            rnd_data <= '0;
        end else begin
            gnt <= '0;
            rnd_valid <= 1'b0;
            if (seed_load) begin
                lfsr <= seed_eff;
                cnt <= '0;
            end else if (state == WARM) begin
                lfsr <= lfsr_step;
                cnt <= (cnt == 8'hff) ? cnt : cnt + 8'd1;
            end else if (grant) begin
                gnt <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                rnd_valid <= 1'b1;
                rnd_data <= lfsr;
                lfsr <= lfsr_step;
                rr <= (pick == RW'(NREQ - 1)) ? '0 : pick + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rand_server.sv
// tb_rand_server: directed checks of warm-up, round-robin, priority, reset and zero-seed behaviour.
module tb_rand_server;
    logic clk = 1'b0, reset = 1'b1, seed_load = 1'b0, rnd_valid, busy;
    logic [63:0] seed = '0, rnd_data;
    logic [3:0] req = '0, gnt;
    int checks = 0, errors = 0;

    rand_server #(.NREQ(4), .WARMUP(4)) dut (
        .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load),
        .req(req), .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic grant(input string tag, input logic [3:0] g, input logic [63:0] d);
        tick();
        check({tag, "_gnt"}, 64'(gnt), 64'(g));
        check({tag, "_valid"}, 64'(rnd_valid), 64'(1));
        check({tag, "_data"}, rnd_data, d);
    endtask

    task automatic idle(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'h0);
        check({tag, "_valid"}, 64'(rnd_valid), 64'h0);
    endtask

    task automatic load(input logic [63:0] s);
        seed = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    initial begin
        tick();
        check("rst_busy", 64'(busy), 64'h1);
        idle("rst");
        check("rst_data", rnd_data, 64'h0);
        reset = 1'b0;
        req = 4'b1111;
        repeat (3) tick();
        idle("unseeded");
        check("unseeded_busy", 64'(busy), 64'h1);
        req = 4'b0000;
        load(64'h1);
        for (int i = 0; i < 3; i++) begin
            check("warm_busy", 64'(busy), 64'h1);
            tick();
        end
        check("warm_busy_last", 64'(busy), 64'h1);
        tick();
        check("ready_busy", 64'(busy), 64'h0);
        idle("ready_idle");
        req = 4'b1111;
        grant("rr0", 4'b0001, 64'h10);
        grant("rr1", 4'b0010, 64'h20);
        grant("rr2", 4'b0100, 64'h40);
        grant("rr3", 4'b1000, 64'h80);
        grant("rr4", 4'b0001, 64'h100);
        req = 4'b0000;
        tick();
        idle("noreq");
        check("hold_data", rnd_data, 64'h100);
        req = 4'b1001;
        grant("skip0", 4'b1000, 64'h200);
        grant("skip1", 4'b0001, 64'h400);
        req = 4'b0010;
        load(64'h8000_0000_0000_0000);
        idle("prio");
        check("prio_busy", 64'(busy), 64'h1);
        repeat (3) tick();
        check("prio_warm", 64'(busy), 64'h1);
        idle("prio_warm");
        tick();
        idle("prio_ready");
        grant("prio_gnt", 4'b0010, 64'h8);
        req = 4'b1111;
        grant("midgnt", 4'b0100, 64'h10);
        reset = 1'b1;
        #1;
        idle("midgnt_rst");
        check("midgnt_rst_data", rnd_data, 64'h0);
        tick();
        reset = 1'b0;
        req = 4'b0000;
        load(64'h1);
        tick();
        reset = 1'b1;
        #1;
        idle("midwarm_rst");
        check("midwarm_rst_busy", 64'(busy), 64'h1);
        check("midwarm_rst_data", rnd_data, 64'h0);
        tick();
        reset = 1'b0;
        req = 4'b0001;
        repeat (6) tick();
        idle("post_rst");
        req = 4'b0000;
        load(64'h0);
        repeat (4) tick();
        check("zero_ready", 64'(busy), 64'h0);
        req = 4'b0001;
`ifdef RAND_SERVER_ZERO_GUARD_EN
        grant("zero", 4'b0001, 64'h10);
`else
        grant("zero", 4'b0001, 64'h0);
`endif
        req = 4'b0000;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
